vu_vmu_load_resp_queue: RTL and testbench

In-order load-response queue for the vector memory unit, directly upstream of the byte/halfword/word/doubleword select stage. It records the sub-word metadata of each issued load (address low bits, access size, extension mode). It captures the matching 128-bit memory response when it returns and presents paired {data, metadata} to the select stage through a valid/ready handshake. It also provides credit-based flow control, because the memory response port has no backpressure.

---
 rtl/vu_vmu_load_resp_queue.sv | 105 ++++++++++
 tb/tb_vu_vmu_load_resp_queue.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vu_vmu_load_resp_queue.sv
// In-order load-response queue for the vector memory unit: pairs each returning
// 128-bit memory line with the sub-word metadata recorded when the load issued.
module vu_vmu_load_resp_queue #(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_val,
    output logic               req_rdy,
    input  logic [3:0]         req_addr_lsb,
    input  logic [1:0]         req_bhwd_sel,
    input  logic               req_signext,
    input  logic               resp_val,
    input  logic [127:0]       resp_data,
    output logic               deq_val,
    input  logic               deq_rdy,
    output logic [127:0]       deq_din,
    output logic [3:0]         deq_addr_lsb,
    output logic [1:0]         deq_bhwd_sel,
    output logic               deq_signext,
    output logic [PTR_W:0]     outstanding,
    output logic               err_unexp_resp
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [127:0]     data_q [DEPTH];
    logic [3:0]       addr_q [DEPTH];
    logic [1:0]       bhwd_q [DEPTH];
    logic [DEPTH-1:0] sext_q;
    logic [DEPTH-1:0] dv_q;

    // Pointers carry a lap bit in the MSB; only the low bits index storage.
    logic [PTR_W:0] alloc_ptr, fill_ptr, deq_ptr, count_q;
    logic [PTR_W-1:0] alloc_idx, fill_idx, deq_idx;

    logic do_alloc, do_fill, do_deq, unexp;

    assign alloc_idx = alloc_ptr[PTR_W-1:0];
    assign fill_idx  = fill_ptr[PTR_W-1:0];
    assign deq_idx   = deq_ptr[PTR_W-1:0];

    // Decisions use registered count/outstanding only, so a same-cycle dequeue
    // never frees a slot and a same-cycle allocate never becomes fillable.
    assign req_rdy  = (count_q < FULL_COUNT);
    assign deq_val  = dv_q[deq_idx] & (count_q != '0);
    assign do_alloc = req_val & req_rdy;
    assign do_fill  = resp_val & (outstanding != '0);
    assign unexp    = resp_val & (outstanding == '0);
    assign do_deq   = deq_val & deq_rdy;

    assign deq_din      = data_q[deq_idx];
    assign deq_addr_lsb = addr_q[deq_idx];
    assign deq_bhwd_sel = bhwd_q[deq_idx];
    assign deq_signext  = sext_q[deq_idx];

    // NOTE: storage is reset as well as the valid bits, so the head outputs read
    // as zero after reset; all sequential state uses non-blocking assignments.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                addr_q[i] <= '0;
                bhwd_q[i] <= '0;
            end
            sext_q <= '0;
            dv_q   <= '0;
        end else begin
            // Allocate, fill and dequeue always target distinct entries.
            if (do_alloc) begin
                addr_q[alloc_idx] <= req_addr_lsb;
                bhwd_q[alloc_idx] <= req_bhwd_sel;
                sext_q[alloc_idx] <= req_signext;
                dv_q[alloc_idx]   <= 1'b0;
            end
            if (do_fill) begin
                data_q[fill_idx] <= resp_data;
                dv_q[fill_idx]   <= 1'b1;
            end
            if (do_deq) begin
                dv_q[deq_idx] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alloc_ptr      <= '0;
            fill_ptr       <= '0;
            deq_ptr        <= '0;
            count_q        <= '0;
            outstanding    <= '0;
            err_unexp_resp <= 1'b0;
        end else begin
            if (do_alloc) alloc_ptr <= alloc_ptr + 1'b1;
            if (do_fill)  fill_ptr  <= fill_ptr + 1'b1;
            if (do_deq)   deq_ptr   <= deq_ptr + 1'b1;
            count_q     <= count_q + (PTR_W + 1)'(do_alloc) - (PTR_W + 1)'(do_deq);
            outstanding <= outstanding + (PTR_W + 1)'(do_alloc) - (PTR_W + 1)'(do_fill);
            if (unexp) err_unexp_resp <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vu_vmu_load_resp_queue.sv
// Directed bench for vu_vmu_load_resp_queue: single load, full, simultaneous
// allocate/fill/dequeue, streaming across wrap, unexpected response, mid-run reset.
module tb_vu_vmu_load_resp_queue;

    localparam int DEPTH = 8;
    localparam int PTR_W = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_val, req_rdy, req_signext;
    logic [3:0]   req_addr_lsb;
    logic [1:0]   req_bhwd_sel;
    logic         resp_val;
    logic [127:0] resp_data;
    logic         deq_val, deq_rdy, deq_signext;
    logic [127:0] deq_din;
    logic [3:0]   deq_addr_lsb;
    logic [1:0]   deq_bhwd_sel;
    logic [PTR_W:0] outstanding;
    logic         err_unexp_resp;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [127:0] data;
        logic [3:0]   addr;
        logic [1:0]   bhwd;
        logic         sext;
    } entry_t;

    vu_vmu_load_resp_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk(clk), .reset(reset),
        .req_val(req_val), .req_rdy(req_rdy), .req_addr_lsb(req_addr_lsb),
        .req_bhwd_sel(req_bhwd_sel), .req_signext(req_signext),
        .resp_val(resp_val), .resp_data(resp_data),
        .deq_val(deq_val), .deq_rdy(deq_rdy), .deq_din(deq_din),
        .deq_addr_lsb(deq_addr_lsb), .deq_bhwd_sel(deq_bhwd_sel), .deq_signext(deq_signext),
        .outstanding(outstanding), .err_unexp_resp(err_unexp_resp)
    );

    always #5 clk = ~clk;

    // Structural invariants, checked between edges.
    always @(negedge clk) begin
        if (!reset) begin
            if (!(outstanding <= dut.count_q && dut.count_q <= 4'(DEPTH))) begin
                $display("FAIL inv_counts: outstanding=%0d count=%0d", outstanding, dut.count_q);
                n_err++;
            end
            if (4'(dut.fill_ptr - dut.deq_ptr) > 4'(dut.alloc_ptr - dut.deq_ptr)) begin
                $display("FAIL inv_ptrs: alloc=%0d fill=%0d deq=%0d",
                         dut.alloc_ptr, dut.fill_ptr, dut.deq_ptr);
                n_err++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_val = 0; req_addr_lsb = 0; req_bhwd_sel = 0; req_signext = 0;
        resp_val = 0; resp_data = '0; deq_rdy = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        tick(); tick();
        reset = 0;
        tick();
        n_vec++; if (req_rdy !== 1'b1) begin $display("FAIL reset_req_rdy: got %b want 1", req_rdy); n_err++; end
        n_vec++; if (deq_val !== 1'b0) begin $display("FAIL reset_deq_val: got %b want 0", deq_val); n_err++; end
        n_vec++; if ({deq_din, deq_addr_lsb, deq_bhwd_sel, deq_signext} !== '0) begin
            $display("FAIL reset_deq_data: got %h/%h/%b/%b want 0", deq_din, deq_addr_lsb, deq_bhwd_sel, deq_signext); n_err++; end
        n_vec++; if (outstanding !== 4'd0) begin $display("FAIL reset_outstanding: got %0d want 0", outstanding); n_err++; end
        n_vec++; if (err_unexp_resp !== 1'b0) begin $display("FAIL reset_err: got %b want 0", err_unexp_resp); n_err++; end
    endtask

    task automatic test_single_load();
        req_val = 1; req_addr_lsb = 4'hA; req_bhwd_sel = 2'b01; req_signext = 0;
        tick();
        req_val = 0;
        n_vec++; if (outstanding !== 4'd1) begin $display("FAIL single_outst_t1: got %0d want 1", outstanding); n_err++; end
        tick();
        resp_val = 1; resp_data = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        n_vec++; if (deq_val !== 1'b0) begin $display("FAIL single_no_bypass: got %b want 0", deq_val); n_err++; end
        tick();
        resp_val = 0;
        n_vec++; if (deq_val !== 1'b1) begin $display("FAIL single_deq_val: got %b want 1", deq_val); n_err++; end
        n_vec++; if (deq_din !== 128'h00112233_44556677_8899AABB_CCDDEEFF) begin
            $display("FAIL single_din: got %h want 00112233445566778899aabbccddeeff", deq_din); n_err++; end
        n_vec++; if ({deq_addr_lsb, deq_bhwd_sel, deq_signext} !== {4'hA, 2'b01, 1'b0}) begin
            $display("FAIL single_meta: got %h/%b/%b want a/01/0", deq_addr_lsb, deq_bhwd_sel, deq_signext); n_err++; end
        n_vec++; if (outstanding !== 4'd0) begin $display("FAIL single_outst_t3: got %0d want 0", outstanding); n_err++; end
        tick();
        n_vec++; if (deq_val !== 1'b1) begin $display("FAIL single_hold: got %b want 1", deq_val); n_err++; end
        deq_rdy = 1;
        tick();
        deq_rdy = 0;
        n_vec++; if (deq_val !== 1'b0) begin $display("FAIL single_drained: got %b want 0", deq_val); n_err++; end
    endtask

    task automatic test_full();
        logic [7:0] d8;
        for (int i = 0; i < DEPTH; i++) begin
            req_val = 1; req_addr_lsb = 4'(i); req_bhwd_sel = 2'(i); req_signext = i[0];
            tick();
        end
        n_vec++; if (req_rdy !== 1'b0) begin $display("FAIL full_req_rdy: got %b want 0", req_rdy); n_err++; end
        n_vec++; if (outstanding !== 4'd8) begin $display("FAIL full_outst: got %0d want 8", outstanding); n_err++; end
        req_addr_lsb = 4'hF;
        tick();
        req_val = 0;
        n_vec++; if (outstanding !== 4'd8) begin $display("FAIL full_reject: got %0d want 8", outstanding); n_err++; end
        resp_val = 1; resp_data = {16{8'h10}};
        tick();
        resp_val = 0;
        n_vec++; if (req_rdy !== 1'b0) begin $display("FAIL full_still_full: got %b want 0", req_rdy); n_err++; end
        n_vec++; if (outstanding !== 4'd7) begin $display("FAIL full_outst7: got %0d want 7", outstanding); n_err++; end
        deq_rdy = 1;
        n_vec++; if (deq_val !== 1'b1 || deq_addr_lsb !== 4'h0) begin
            $display("FAIL full_head: got val=%b addr=%h want 1/0", deq_val, deq_addr_lsb); n_err++; end
        tick();
        deq_rdy = 0;
        n_vec++; if (req_rdy !== 1'b1) begin $display("FAIL full_rdy_restored: got %b want 1", req_rdy); n_err++; end
        for (int i = 1; i < DEPTH; i++) begin
            d8 = 8'h10 + 8'(i);
            resp_val = 1; resp_data = {16{d8}};
            tick();
        end
        resp_val = 0;
        deq_rdy = 1;
        for (int i = 1; i < DEPTH; i++) begin
            d8 = 8'h10 + 8'(i);
            n_vec++;
            if (deq_val !== 1'b1 || deq_din !== {16{d8}} ||
                {deq_addr_lsb, deq_bhwd_sel, deq_signext} !== {4'(i), 2'(i), i[0]}) begin
                $display("FAIL full_drain_%0d: got val=%b din=%h meta=%h/%b/%b", i, deq_val, deq_din,
                         deq_addr_lsb, deq_bhwd_sel, deq_signext); n_err++; end
            tick();
        end
        deq_rdy = 0;
        n_vec++; if (deq_val !== 1'b0 || outstanding !== 4'd0) begin
            $display("FAIL full_empty: got val=%b outst=%0d want 0/0", deq_val, outstanding); n_err++; end
    endtask

    task automatic test_simultaneous();
        logic [PTR_W:0] a0, f0, d0;
        for (int i = 1; i <= 4; i++) begin
            req_val = 1; req_addr_lsb = 4'(i); req_bhwd_sel = 2'(i); req_signext = 0;
            tick();
        end
        req_val = 0;
        for (int i = 0; i < 2; i++) begin
            resp_val = 1; resp_data = 128'hA0 + 128'(i);
            tick();
        end
        resp_val = 0;
        n_vec++; if (dut.count_q !== 4'd4 || outstanding !== 4'd2) begin
            $display("FAIL sim_setup: got count=%0d outst=%0d want 4/2", dut.count_q, outstanding); n_err++; end
        a0 = dut.alloc_ptr; f0 = dut.fill_ptr; d0 = dut.deq_ptr;
        req_val = 1; req_addr_lsb = 4'h5; req_bhwd_sel = 2'h1;
        resp_val = 1; resp_data = 128'hA2;
        deq_rdy = 1;
        n_vec++; if (deq_val !== 1'b1 || deq_din !== 128'hA0 || deq_addr_lsb !== 4'h1) begin
            $display("FAIL sim_head: got val=%b din=%h addr=%h want 1/a0/1", deq_val, deq_din, deq_addr_lsb); n_err++; end
        tick();
        idle_inputs();
        n_vec++; if (dut.count_q !== 4'd4 || outstanding !== 4'd2) begin
            $display("FAIL sim_counts: got count=%0d outst=%0d want 4/2", dut.count_q, outstanding); n_err++; end
        n_vec++; if (dut.alloc_ptr !== 4'(a0 + 1) || dut.fill_ptr !== 4'(f0 + 1) || dut.deq_ptr !== 4'(d0 + 1)) begin
            $display("FAIL sim_ptrs: got %0d/%0d/%0d want %0d/%0d/%0d", dut.alloc_ptr, dut.fill_ptr,
                     dut.deq_ptr, 4'(a0 + 1), 4'(f0 + 1), 4'(d0 + 1)); n_err++; end
        for (int i = 3; i < 5; i++) begin
            resp_val = 1; resp_data = 128'hA0 + 128'(i);
            tick();
        end
        resp_val = 0;
        deq_rdy = 1;
        for (int i = 1; i < 5; i++) begin
            n_vec++;
            if (deq_val !== 1'b1 || deq_din !== 128'hA0 + 128'(i) || deq_addr_lsb !== 4'(i + 1)) begin
                $display("FAIL sim_drain_%0d: got val=%b din=%h addr=%h", i, deq_val, deq_din, deq_addr_lsb); n_err++; end
            tick();
        end
        deq_rdy = 0;
    endtask

    task automatic test_streaming();
        entry_t exp_q[$];
        entry_t e, got_e;
        int sent = 0, got = 0, cyc = 0;
        logic pend = 0, acc;
        logic [127:0] pend_d = '0;
        logic [7:0] k;
        while (got < 3 * DEPTH && cyc < 400) begin
            k = 8'(sent);
            req_val = (sent < 3 * DEPTH);
            req_addr_lsb = 4'(k * 8'd5); req_bhwd_sel = k[1:0]; req_signext = k[2];
            resp_val = pend; resp_data = pend_d;
            deq_rdy = 1'($urandom_range(0, 1));
            acc = req_val & req_rdy;
            if (deq_val && deq_rdy) begin
                got_e = '{deq_din, deq_addr_lsb, deq_bhwd_sel, deq_signext};
                n_vec++;
                if (exp_q.size() == 0) begin
                    $display("FAIL stream_extra: got din=%h with nothing expected", deq_din); n_err++;
                end else begin
                    e = exp_q.pop_front();
                    if (got_e !== e) begin
                        $display("FAIL stream_%0d: got %h/%h/%b/%b want %h/%h/%b/%b", got, got_e.data, got_e.addr,
                                 got_e.bhwd, got_e.sext, e.data, e.addr, e.bhwd, e.sext); n_err++; end
                end
                got++;
            end
            if (acc) begin
                e = '{{4{32'hC0DE0000 | 32'(k)}}, req_addr_lsb, req_bhwd_sel, req_signext};
                exp_q.push_back(e);
                pend_d = e.data;
                sent++;
            end
            pend = acc;
            tick();
            cyc++;
        end
        idle_inputs();
        n_vec++; if (got != 3 * DEPTH) begin $display("FAIL stream_timeout: got %0d entries want %0d", got, 3 * DEPTH); n_err++; end
        n_vec++; if (outstanding !== 4'd0 || deq_val !== 1'b0 || err_unexp_resp !== 1'b0) begin
            $display("FAIL stream_end: got outst=%0d val=%b err=%b want 0/0/0", outstanding, deq_val, err_unexp_resp); n_err++; end
    endtask

    task automatic test_unexp_resp();
        logic [PTR_W:0] a0, f0, d0;
        a0 = dut.alloc_ptr; f0 = dut.fill_ptr; d0 = dut.deq_ptr;
        resp_val = 1; resp_data = 128'hDEAD;
        tick();
        resp_val = 0;
        n_vec++; if (err_unexp_resp !== 1'b1) begin $display("FAIL unexp_err: got %b want 1", err_unexp_resp); n_err++; end
        n_vec++; if (outstanding !== 4'd0 || dut.count_q !== 4'd0 || deq_val !== 1'b0) begin
            $display("FAIL unexp_counts: got outst=%0d count=%0d val=%b want 0/0/0", outstanding, dut.count_q, deq_val); n_err++; end
        n_vec++; if (dut.alloc_ptr !== a0 || dut.fill_ptr !== f0 || dut.deq_ptr !== d0) begin
            $display("FAIL unexp_ptrs: got %0d/%0d/%0d want %0d/%0d/%0d", dut.alloc_ptr, dut.fill_ptr, dut.deq_ptr, a0, f0, d0); n_err++; end
        tick(); tick();
        n_vec++; if (err_unexp_resp !== 1'b1) begin $display("FAIL unexp_sticky: got %b want 1", err_unexp_resp); n_err++; end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            req_val = 1; req_addr_lsb = 4'(i + 7); req_bhwd_sel = 2'b11; req_signext = 1;
            tick();
        end
        req_val = 0;
        n_vec++; if (outstanding !== 4'd3) begin $display("FAIL rmid_outst3: got %0d want 3", outstanding); n_err++; end
        #2 reset = 1;
        #1;
        n_vec++; if (req_rdy !== 1'b1 || deq_val !== 1'b0 || outstanding !== 4'd0 || err_unexp_resp !== 1'b0) begin
            $display("FAIL rmid_async: got rdy=%b val=%b outst=%0d err=%b want 1/0/0/0", req_rdy, deq_val,
                     outstanding, err_unexp_resp); n_err++; end
        n_vec++; if ({deq_din, deq_addr_lsb, deq_bhwd_sel, deq_signext} !== '0) begin
            $display("FAIL rmid_deq_data: got %h/%h/%b/%b want 0", deq_din, deq_addr_lsb, deq_bhwd_sel, deq_signext); n_err++; end
        tick();
        reset = 0;
        tick();
        resp_val = 1; resp_data = 128'hBEEF;
        tick();
        resp_val = 0;
        n_vec++; if (err_unexp_resp !== 1'b1 || outstanding !== 4'd0 || deq_val !== 1'b0 || req_rdy !== 1'b1) begin
            $display("FAIL rmid_late_resp: got err=%b outst=%0d val=%b rdy=%b want 1/0/0/1", err_unexp_resp,
                     outstanding, deq_val, req_rdy); n_err++; end
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_full();
        test_simultaneous();
        test_streaming();
        test_unexp_resp();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
